// File: rtl/collision_detector_if.sv
// Sprite move/collision handshake plus obstacle-map read port for collision_detector.
// COLLISION_SPRITE_EN adds the second-sprite position signals.
interface collision_detector_if;
  logic        check_start;
  logic [8:0]  x_pos;
  logic [7:0]  y_pos;
  logic [2:0]  direction;
  logic [16:0] map_address;
  logic        map_data;
  logic        busy;
  logic        collision;
  logic        check_done;
`ifdef COLLISION_SPRITE_EN
  logic [8:0]  other_x;
  logic [7:0]  other_y;

  modport master (
    output check_start, x_pos, y_pos, direction, other_x, other_y, map_data,
    input  map_address, busy, collision, check_done
  );
  modport slave (
    input  check_start, x_pos, y_pos, direction, other_x, other_y, map_data,
    output map_address, busy, collision, check_done
  );
`else
  modport master (
    output check_start, x_pos, y_pos, direction, map_data,
    input  map_address, busy, collision, check_done
  );
  modport slave (
    input  check_start, x_pos, y_pos, direction, map_data,
    output map_address, busy, collision, check_done
  );
`endif
endinterface

// File: rtl/collision_detector.sv
// Probes the one-pixel strip a sprite would move into (obstacle RAM + screen bounds) and reports collision.
// Optional macro COLLISION_SPRITE_EN adds a sprite-vs-sprite overlap test on the moved box.
module collision_detector #(
  parameter int unsigned SPRITE_SIZE = 16,
  parameter int unsigned SCREEN_W    = 320,
  parameter int unsigned SCREEN_H    = 240
) (
  input  logic               clock,
  input  logic               reset,
  collision_detector_if.slave bus
);
  localparam int IDX_W = $clog2(SPRITE_SIZE);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SPRITE_SIZE - 1);
  localparam logic [2:0] DIR_UP    = 3'b010;
  localparam logic [2:0] DIR_DOWN  = 3'b011;
  localparam logic [2:0] DIR_LEFT  = 3'b100;
  localparam logic [2:0] DIR_RIGHT = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

  state_t           state, next_state;
  logic [8:0]       x_lat;
  logic [7:0]       y_lat;
  logic [2:0]       dir_lat;
  logic [IDX_W-1:0] idx;
  logic             hit, rd_valid, ov_r;
  logic [16:0]      addr_r;
  logic             busy_r, done_r, collision_r;
  logic             is_move, edge_block, ov_s, hit_next;

  // Wide coordinates of strip pixel k so that overflow past the screen edge stays visible.
  function automatic logic [18:0] probe_xy(input logic [8:0] x, input logic [7:0] y,
                                           input logic [2:0] dir, input logic [IDX_W-1:0] k);
    logic [9:0] px;
    logic [8:0] py;
    px = {1'b0, x};
    py = {1'b0, y};
    case (dir)
      DIR_UP:    begin px = {1'b0, x} + 10'(k);           py = {1'b0, y} - 9'd1;          end
      DIR_DOWN:  begin px = {1'b0, x} + 10'(k);           py = {1'b0, y} + 9'(SPRITE_SIZE); end
      DIR_LEFT:  begin px = {1'b0, x} - 10'd1;            py = {1'b0, y} + 9'(k);         end
      DIR_RIGHT: begin px = {1'b0, x} + 10'(SPRITE_SIZE); py = {1'b0, y} + 9'(k);         end
      default:   begin px = {1'b0, x};                    py = {1'b0, y};                 end
    endcase
    probe_xy = {py, px};
  endfunction

  function automatic logic [16:0] probe_addr(input logic [8:0] x, input logic [7:0] y,
                                             input logic [2:0] dir, input logic [IDX_W-1:0] k);
    logic [18:0] xy;
    xy = probe_xy(x, y, dir, k);
    probe_addr = {xy[17:10], xy[8:0]};
  endfunction

  function automatic logic probe_oob(input logic [8:0] x, input logic [7:0] y,
                                     input logic [2:0] dir, input logic [IDX_W-1:0] k);
    logic [18:0] xy;
    xy = probe_xy(x, y, dir, k);
    probe_oob = (xy[9:0] >= 10'(SCREEN_W)) || (xy[18:10] >= 9'(SCREEN_H));
  endfunction

`ifdef COLLISION_SPRITE_EN
  localparam logic signed [10:0] SZ = 11'(SPRITE_SIZE);

  function automatic logic overlap(input logic [8:0] x, input logic [7:0] y, input logic [2:0] dir,
                                   input logic [8:0] ox, input logic [7:0] oy);
    logic signed [10:0] mx, my, dx, dy;
    mx = $signed({2'b00, x});
    my = $signed({3'b000, y});
    case (dir)
      DIR_UP:    my = my - 11'sd1;
      DIR_DOWN:  my = my + 11'sd1;
      DIR_LEFT:  mx = mx - 11'sd1;
      DIR_RIGHT: mx = mx + 11'sd1;
      default:   mx = mx;
    endcase
    dx = mx - $signed({2'b00, ox});
    dy = my - $signed({3'b000, oy});
    overlap = (dx < SZ) && (dx > -SZ) && (dy < SZ) && (dy > -SZ);
  endfunction

  assign ov_s = overlap(bus.x_pos, bus.y_pos, bus.direction, bus.other_x, bus.other_y)
                && (bus.direction >= DIR_UP);
`else
  assign ov_s = 1'b0;
`endif

  // Moves that would leave the screen are answered immediately without touching the RAM.
  always_comb begin
    is_move    = (bus.direction >= DIR_UP) && (bus.direction <= DIR_RIGHT);
    edge_block = 1'b0;
    case (bus.direction)
      DIR_UP:    edge_block = (bus.y_pos == 8'd0);
      DIR_DOWN:  edge_block = (({1'b0, bus.y_pos} + 9'(SPRITE_SIZE)) > 9'(SCREEN_H - 1));
      DIR_LEFT:  edge_block = (bus.x_pos == 9'd0);
      DIR_RIGHT: edge_block = (({1'b0, bus.x_pos} + 10'(SPRITE_SIZE)) > 10'(SCREEN_W - 1));
      default:   edge_block = 1'b0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (bus.check_start) begin
          if (is_move && !edge_block) next_state = S_SCAN;
          else                        next_state = S_DONE;
        end else begin
          next_state = S_IDLE;
        end
      end
      S_SCAN: begin
        if (idx == IDX_LAST) next_state = S_DRAIN;
        else                 next_state = S_SCAN;
      end
      S_DRAIN: next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Accumulated hit including the RAM word returning this cycle and an off-screen strip pixel.
  always_comb begin
    hit_next = hit | (rd_valid & bus.map_data);
    if (state == S_SCAN) hit_next = hit_next | probe_oob(x_lat, y_lat, dir_lat, idx);
    else                 hit_next = hit_next;
  end

  // State register, request latch, scan address generation and registered results.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      x_lat       <= 9'd0;
      y_lat       <= 8'd0;
      dir_lat     <= 3'd0;
      idx         <= '0;
      hit         <= 1'b0;
      rd_valid    <= 1'b0;
      ov_r        <= 1'b0;
      addr_r      <= 17'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      collision_r <= 1'b0;
    end else begin
      state    <= next_state;
      busy_r   <= (next_state != S_IDLE);
      done_r   <= (next_state == S_DONE);
      rd_valid <= (state == S_SCAN);
      case (state)
        S_IDLE: begin
          if (bus.check_start) begin
            x_lat   <= bus.x_pos;
            y_lat   <= bus.y_pos;
            dir_lat <= bus.direction;
            idx     <= '0;
            hit     <= 1'b0;
            ov_r    <= ov_s;
            if (next_state == S_SCAN)
              addr_r <= probe_addr(bus.x_pos, bus.y_pos, bus.direction, '0);
            else
              collision_r <= (is_move & edge_block) | ov_s;
          end
        end
        S_SCAN: begin
          idx <= idx + 1'b1;
          hit <= hit_next;
          if (idx != IDX_LAST) addr_r <= probe_addr(x_lat, y_lat, dir_lat, idx + 1'b1);
        end
        S_DRAIN: begin
          hit         <= hit_next;
          collision_r <= hit_next | ov_r;
        end
        default: hit <= hit;
      endcase
    end
  end

  assign bus.map_address = addr_r;
  assign bus.busy        = busy_r;
  assign bus.check_done  = done_r;
  assign bus.collision   = collision_r;
endmodule

// File: tb/tb_collision_detector.sv
// Directed self-checking bench for collision_detector with a behavioural 1-cycle obstacle RAM.
module tb_collision_detector;
  logic clock = 1'b0;
  logic reset;
  collision_detector_if bus();

  collision_detector dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  bit mem [0:131071];
  always @(posedge clock) bus.map_data <= mem[bus.map_address];

  int total = 0;
  int bad   = 0;
  logic [16:0] addr_log [0:15];

  localparam logic [2:0] NOP = 3'b000, ATK = 3'b001, UP = 3'b010, DN = 3'b011, LT = 3'b100, RT = 3'b101;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One full request: start pulse, scrambled inputs afterwards, optional extra start at poke_cyc.
  task automatic run(input string tag, input int x, input int y, input logic [2:0] dir,
                     input int exp_lat, input logic exp_col, input int poke_cyc);
    int cyc;
    @(negedge clock);
    bus.x_pos = 9'(x);
    bus.y_pos = 8'(y);
    bus.direction = dir;
    bus.check_start = 1'b1;
    @(negedge clock);
    bus.check_start = 1'b0;
    bus.x_pos = 9'd0;
    bus.y_pos = 8'd0;
    bus.direction = NOP;
    cyc = 1;
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    while (!bus.check_done && cyc < 40) begin
      if (cyc <= 16) addr_log[cyc-1] = bus.map_address;
      if (cyc == poke_cyc) begin
        bus.direction = ATK;
        bus.check_start = 1'b1;
      end
      @(negedge clock);
      bus.check_start = 1'b0;
      cyc++;
    end
    chk({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
    chk({tag, "_col"}, 32'(bus.collision), 32'(exp_col));
    @(negedge clock);
    chk({tag, "_idle"}, 32'({bus.busy, bus.check_done}), 32'd0);
    chk({tag, "_hold"}, 32'(bus.collision), 32'(exp_col));
  endtask

  initial begin
    int cyc;
    reset = 1'b1;
    bus.check_start = 1'b0;
    bus.x_pos = 9'd0;
    bus.y_pos = 8'd0;
    bus.direction = NOP;
`ifdef COLLISION_SPRITE_EN
    bus.other_x = 9'd300;
    bus.other_y = 8'd200;
`endif
    repeat (3) @(negedge clock);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.check_done), 32'd0);
    chk("rst_col", 32'(bus.collision), 32'd0);
    chk("rst_addr", 32'(bus.map_address), 32'd0);
    reset = 1'b0;

    run("up_empty", 100, 100, UP, 18, 1'b0, 0);
    for (int i = 0; i < 16; i++) chk($sformatf("up_addr%0d", i), 32'(addr_log[i]), 32'(99 * 512 + 100 + i));

    mem[105 * 512 + 120] = 1'b1;
    run("right_hit_poke", 104, 100, RT, 18, 1'b1, 5);
    run("left_clear", 104, 100, LT, 18, 1'b0, 0);
    run("up_y0", 100, 0, UP, 1, 1'b1, 0);
    run("right_x304", 304, 50, RT, 1, 1'b1, 0);
    run("left_x0", 0, 50, LT, 1, 1'b1, 0);
    run("down_y224", 50, 224, DN, 1, 1'b1, 0);
    run("attack", 100, 100, ATK, 1, 1'b0, 0);
    run("down_y223", 50, 223, DN, 18, 1'b0, 0);
    run("noaction", 100, 100, NOP, 1, 1'b0, 0);
    run("up_strip_oob", 310, 50, UP, 18, 1'b1, 0);

    // Reset in the middle of a scan while collision still holds 1.
    @(negedge clock);
    bus.x_pos = 9'd100;
    bus.y_pos = 8'd100;
    bus.direction = DN;
    bus.check_start = 1'b1;
    @(negedge clock);
    bus.check_start = 1'b0;
    cyc = 1;
    while (cyc < 8) begin
      @(negedge clock);
      cyc++;
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_col", 32'(bus.collision), 32'd0);
    chk("midrst_addr", 32'(bus.map_address), 32'd0);
    run("fresh_up", 100, 100, UP, 18, 1'b0, 0);

    run("right_edge_ok", 303, 50, RT, 18, 1'b0, 0);
    run("dir110", 100, 100, 3'b110, 1, 1'b0, 0);

`ifdef COLLISION_SPRITE_EN
    bus.other_x = 9'd116;
    bus.other_y = 8'd100;
    run("spr_overlap", 100, 100, RT, 18, 1'b1, 0);
    bus.other_x = 9'd117;
    run("spr_apart", 100, 100, RT, 18, 1'b0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
